// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for the bit-serial subtractor: operands in,
// busy/done status and the registered result out.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtraction cell processes one bit per
// clock, LSB first, with a borrow flop chaining the bits together.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             d_bit;
  logic             br_bit;
  logic [WIDTH-1:0] res_shift;

  // Full-subtraction cell on the current LSBs and the chained borrow.
  assign d_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign br_bit = (~a_q[0] & b_q[0]) | (~a_q[0] & c_q) | (b_q[0] & c_q);

  // New difference bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_shift = d_bit;
    end else begin : g_res_multi
      assign res_shift = {d_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = br_bit;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          bout_d  = br_bit;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
